vga_mode_ctrl: RTL and testbench

- Sequences display-mode changes for the VGA pixel pipeline.
- Accepts a mode request over a valid/ready handshake and waits for a frame boundary from the timing driver's vertical sync.
- Blanks the pixel output for a fixed number of frames, then loads a new timing set and clock-divider select in one cycle.
- Releases the blank after a settle period. Sits between the top-level control logic and the timing driver / clock divider.

---
 rtl/vga_mode_ctrl_pkg.sv | 39 +++
 rtl/vga_mode_ctrl_if.sv | 32 +++
 rtl/vga_mode_ctrl_frame_edge.sv | 37 +++
 rtl/vga_mode_ctrl.sv | 150 +++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_mode_ctrl_pkg.sv
// Shared types and the fixed mode timing table for the VGA mode-change controller.
package vga_mode_pkg;

  localparam int unsigned TW     = 12;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned DIV_W  = 2;
  localparam int unsigned GAIN_W = 8;

  typedef logic [MODE_W-1:0] mode_t;

  typedef struct packed {
    logic [TW-1:0]    h_disp;
    logic [TW-1:0]    h_front;
    logic [TW-1:0]    h_sync;
    logic [TW-1:0]    h_back;
    logic [TW-1:0]    v_disp;
    logic [TW-1:0]    v_front;
    logic [TW-1:0]    v_sync;
    logic [TW-1:0]    v_back;
    logic [DIV_W-1:0] div;
  } timing_t;

  localparam timing_t MODE_TABLE [4] = '{
    '{12'd640,  12'd16, 12'd96,  12'd48,  12'd480, 12'd10, 12'd2,  12'd33, 2'd0},
    '{12'd800,  12'd40, 12'd128, 12'd88,  12'd600, 12'd1,  12'd4,  12'd23, 2'd1},
    '{12'd480,  12'd2,  12'd41,  12'd2,   12'd272, 12'd2,  12'd10, 12'd2,  2'd2},
    '{12'd1024, 12'd24, 12'd136, 12'd160, 12'd768, 12'd3,  12'd6,  12'd29, 2'd3}
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_EDGE,
    ST_BLANK,
    ST_LOAD,
    ST_SETTLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// Request handshake, frame sync and timing/blanking outputs of vga_mode_ctrl.
interface vga_mode_ctrl_if;
  import vga_mode_pkg::*;

  logic              lcd_vs;
  logic              mode_req_valid;
  mode_t             mode_req_sel;
  logic              mode_req_ready;
  logic              mode_done;
  logic              busy;
  mode_t             cur_mode;
  logic [TW-1:0]     h_disp, h_front, h_sync, h_back;
  logic [TW-1:0]     v_disp, v_front, v_sync, v_back;
  logic [DIV_W-1:0]  clk_div_sel;
  logic              timing_load;
  logic              pix_blank;
  logic [GAIN_W-1:0] pix_gain;

  modport master (
    output lcd_vs, mode_req_valid, mode_req_sel,
    input  mode_req_ready, mode_done, busy, cur_mode,
    input  h_disp, h_front, h_sync, h_back, v_disp, v_front, v_sync, v_back,
    input  clk_div_sel, timing_load, pix_blank, pix_gain
  );

  modport slave (
    input  lcd_vs, mode_req_valid, mode_req_sel,
    output mode_req_ready, mode_done, busy, cur_mode,
    output h_disp, h_front, h_sync, h_back, v_disp, v_front, v_sync, v_back,
    output clk_div_sel, timing_load, pix_blank, pix_gain
  );
endinterface

// File: rtl/vga_mode_ctrl_frame_edge.sv
// Frame-edge detector: registered vsync, active-going edge, and a watchdog that
// fakes an edge after TIMEOUT_CYC idle cycles while i_cnt_en is high.
module vga_frame_edge #(
  parameter int unsigned VS_ACTIVE_LOW = 1,
  parameter int unsigned TIMEOUT_CYC   = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vs,
  input  logic i_cnt_en,
  output logic o_frame_edge_c
);
  localparam int unsigned CNT_W   = 24;
  localparam logic        VS_ACT  = (VS_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] TO_CYC = CNT_W'(TIMEOUT_CYC);

  logic             r_vs;
  logic [CNT_W-1:0] r_cnt;
  logic             w_vs_edge;
  logic             w_timeout;

  assign w_vs_edge      = (i_vs == VS_ACT) && (r_vs != VS_ACT);
  assign w_timeout      = i_cnt_en && (r_cnt == TO_CYC);
  assign o_frame_edge_c = w_vs_edge || w_timeout;

  // Counter is held at zero outside the waiting states, so every entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs  <= ~VS_ACT;
      r_cnt <= '0;
    end else begin
      r_vs <= i_vs;
      if (!i_cnt_en || o_frame_edge_c) r_cnt <= '0;
      else                             r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/vga_mode_ctrl.sv
// Display mode-change sequencer: waits for a frame edge, blanks, loads new timing, settles.
// Build option: VGA_MODE_FADE_EN enables a brightness ramp during the settle phase.
module vga_mode_ctrl
  import vga_mode_pkg::*;
#(
  parameter int unsigned DEFAULT_MODE  = 0,
  parameter int unsigned BLANK_FRAMES  = 2,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned VS_ACTIVE_LOW = 1,
  parameter int unsigned TIMEOUT_CYC   = 2000000
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_mode_ctrl_if.slave  bus
);
  localparam mode_t      DEF_MODE    = MODE_W'(DEFAULT_MODE);
  localparam timing_t    DEF_TIMING  = MODE_TABLE[DEF_MODE];
  localparam logic [3:0] BLANK_LAST  = 4'(BLANK_FRAMES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES - 1);
`ifdef VGA_MODE_FADE_EN
  localparam logic [GAIN_W-1:0] GAIN_STEP = GAIN_W'(255 / SETTLE_FRAMES);
`endif

  state_t            r_state;
  mode_t             r_req_mode;
  mode_t             r_cur_mode;
  timing_t           r_timing;
  logic              r_timing_load;
  logic              r_mode_done;
  logic              r_pix_blank;
  logic [GAIN_W-1:0] r_pix_gain;
  logic              r_busy;
  logic [3:0]        r_frames;
  logic              w_frame_edge;
  logic              w_cnt_en;

  assign w_cnt_en = (r_state == ST_WAIT_EDGE) || (r_state == ST_BLANK) ||
                    (r_state == ST_SETTLE);

  vga_frame_edge #(
    .VS_ACTIVE_LOW (VS_ACTIVE_LOW),
    .TIMEOUT_CYC   (TIMEOUT_CYC)
  ) u_frame_edge (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_vs           (bus.lcd_vs),
    .i_cnt_en       (w_cnt_en),
    .o_frame_edge_c (w_frame_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_req_mode    <= DEF_MODE;
      r_cur_mode    <= DEF_MODE;
      r_timing      <= DEF_TIMING;
      r_timing_load <= 1'b0;
      r_mode_done   <= 1'b0;
      r_pix_blank   <= 1'b0;
      r_pix_gain    <= GAIN_W'(255);
      r_busy        <= 1'b0;
      r_frames      <= '0;
    end else begin
      r_timing_load <= 1'b0;
      r_mode_done   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.mode_req_valid) begin
            r_req_mode <= bus.mode_req_sel;
            r_busy     <= 1'b1;
            // Re-requesting the active mode completes without touching the display.
            if (bus.mode_req_sel == r_cur_mode) begin
              r_mode_done <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_WAIT_EDGE;
            end
          end
        end
        ST_WAIT_EDGE: begin
          if (w_frame_edge) begin
            r_pix_blank <= 1'b1;
            r_frames    <= '0;
`ifdef VGA_MODE_FADE_EN
            r_pix_gain  <= '0;
`endif
            r_state     <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (w_frame_edge) begin
            if (r_frames == BLANK_LAST) begin
              r_timing      <= MODE_TABLE[r_req_mode];
              r_cur_mode    <= r_req_mode;
              r_timing_load <= 1'b1;
              r_frames      <= '0;
              r_state       <= ST_LOAD;
            end else begin
              r_frames <= r_frames + 4'd1;
            end
          end
        end
        ST_LOAD: begin
          r_frames <= '0;
          r_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_frame_edge) begin
            if (r_frames == SETTLE_LAST) begin
              r_pix_blank <= 1'b0;
              r_mode_done <= 1'b1;
`ifdef VGA_MODE_FADE_EN
              r_pix_gain  <= GAIN_W'(255);
`endif
              r_state     <= ST_DONE;
            end else begin
              r_frames <= r_frames + 4'd1;
`ifdef VGA_MODE_FADE_EN
              r_pix_blank <= 1'b0;
              r_pix_gain  <= r_pix_gain + GAIN_STEP;
`endif
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mode_req_ready = ~r_busy;
  assign bus.busy           = r_busy;
  assign bus.mode_done      = r_mode_done;
  assign bus.cur_mode       = r_cur_mode;
  assign bus.h_disp         = r_timing.h_disp;
  assign bus.h_front        = r_timing.h_front;
  assign bus.h_sync         = r_timing.h_sync;
  assign bus.h_back         = r_timing.h_back;
  assign bus.v_disp         = r_timing.v_disp;
  assign bus.v_front        = r_timing.v_front;
  assign bus.v_sync         = r_timing.v_sync;
  assign bus.v_back         = r_timing.v_back;
  assign bus.clk_div_sel    = r_timing.div;
  assign bus.timing_load    = r_timing_load;
  assign bus.pix_blank      = r_pix_blank;
  assign bus.pix_gain       = r_pix_gain;
endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl: vector table of mode requests plus handshake,
// timeout and asynchronous-reset sequences.
module tb_vga_mode_ctrl;
  import vga_mode_pkg::*;

`ifdef VGA_MODE_FADE_EN
  localparam int EXP_FALL_E    = 4;
  localparam int EXP_LOAD_GAIN = 0;
  localparam int EXP_MID_GAIN  = 127;
  localparam int EXP_MIN_GAIN  = 0;
`else
  localparam int EXP_FALL_E    = 5;
  localparam int EXP_LOAD_GAIN = 255;
  localparam int EXP_MID_GAIN  = 255;
  localparam int EXP_MIN_GAIN  = 255;
`endif

  typedef struct {
    int n_load, n_done, blank_seen;
    int rise_e, load_e, fall_e, done_e, done_cyc;
    int ld_h, ld_v, ld_div;
    int load_gain, mid_gain, min_gain, done_gain;
  } res_t;

  typedef struct {
    logic [1:0] sel;
    int         change;
    int         h, v, div;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec, n_miss;
  int   vs_cnt, vs_edges;

  vga_mode_ctrl_if mif ();
  vga_mode_ctrl_if mif2 ();

  vga_mode_ctrl #(
    .DEFAULT_MODE(0), .BLANK_FRAMES(2), .SETTLE_FRAMES(2),
    .VS_ACTIVE_LOW(1), .TIMEOUT_CYC(2000000)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(mif));

  vga_mode_ctrl #(
    .DEFAULT_MODE(0), .BLANK_FRAMES(2), .SETTLE_FRAMES(2),
    .VS_ACTIVE_LOW(1), .TIMEOUT_CYC(100)
  ) dut_to (.clk(clk), .rst_n(rst_n), .bus(mif2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low vsync pulse every 1000 clocks, driven just after the rising edge.
  initial begin
    vs_cnt   = 0;
    vs_edges = 0;
    mif.lcd_vs = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      vs_cnt = (vs_cnt == 999) ? 0 : vs_cnt + 1;
      if (vs_cnt == 0) begin
        mif.lcd_vs = 1'b0;
        vs_edges++;
      end else if (vs_cnt == 3) begin
        mif.lcd_vs = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Observe dut until mode_done; edge indices are relative to the acceptance edge.
  task automatic wait_done(input int max_cyc, input int base, output res_t r);
    int consumed;
    int rel;
    consumed = base;
    r = '{n_load: 0, n_done: 0, blank_seen: 0, rise_e: -1, load_e: -1, fall_e: -1,
          done_e: -1, done_cyc: -1, ld_h: -1, ld_v: -1, ld_div: -1,
          load_gain: -1, mid_gain: -1, min_gain: 255, done_gain: -1};
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (i == 0) mif.mode_req_valid = 1'b0;
      rel      = consumed - base;
      consumed = vs_edges;
      if (int'(mif.pix_gain) < r.min_gain) r.min_gain = int'(mif.pix_gain);
      if (rel == 4 && r.mid_gain < 0) r.mid_gain = int'(mif.pix_gain);
      if (mif.pix_blank && r.blank_seen == 0) begin
        r.blank_seen = 1;
        r.rise_e     = rel;
      end else if (r.blank_seen == 1 && !mif.pix_blank && r.fall_e < 0) begin
        r.fall_e = rel;
      end
      if (mif.timing_load) begin
        r.n_load++;
        r.load_e    = rel;
        r.ld_h      = int'(mif.h_disp);
        r.ld_v      = int'(mif.v_disp);
        r.ld_div    = int'(mif.clk_div_sel);
        r.load_gain = int'(mif.pix_gain);
      end
      if (mif.mode_done) begin
        r.n_done++;
        r.done_e    = rel;
        r.done_cyc  = i;
        r.done_gain = int'(mif.pix_gain);
        break;
      end
    end
  endtask

  task automatic do_req(input logic [1:0] sel, output res_t r);
    int base;
    for (int k = 0; k < 10000 && !mif.mode_req_ready; k++) @(negedge clk);
    chk("ready_before_req", int'(mif.mode_req_ready), 1);
    mif.mode_req_sel   = sel;
    mif.mode_req_valid = 1'b1;
    base = vs_edges;
    wait_done(8000, base, r);
  endtask

  initial begin
    vec_t tbl [6];
    res_t r;
    int   viol, seen, ld_i, done_i, ld_h, blank_at_ld;
    string nm;

    tbl[0] = '{sel: 2'd1, change: 1, h: 800,  v: 600, div: 1};
    tbl[1] = '{sel: 2'd1, change: 0, h: 800,  v: 600, div: 1};
    tbl[2] = '{sel: 2'd3, change: 1, h: 1024, v: 768, div: 3};
    tbl[3] = '{sel: 2'd3, change: 0, h: 1024, v: 768, div: 3};
    tbl[4] = '{sel: 2'd0, change: 1, h: 640,  v: 480, div: 0};
    tbl[5] = '{sel: 2'd2, change: 1, h: 480,  v: 272, div: 2};

    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    mif.mode_req_valid  = 1'b0;
    mif.mode_req_sel    = 2'd0;
    mif2.mode_req_valid = 1'b0;
    mif2.mode_req_sel   = 2'd0;
    mif2.lcd_vs         = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_h_disp", int'(mif.h_disp), 640);
    chk("rst_v_disp", int'(mif.v_disp), 480);
    chk("rst_h_sync", int'(mif.h_sync), 96);
    chk("rst_v_back", int'(mif.v_back), 33);
    chk("rst_div", int'(mif.clk_div_sel), 0);
    chk("rst_ready", int'(mif.mode_req_ready), 1);
    chk("rst_busy", int'(mif.busy), 0);
    chk("rst_blank", int'(mif.pix_blank), 0);
    chk("rst_gain", int'(mif.pix_gain), 255);
    chk("rst_load", int'(mif.timing_load), 0);
    chk("rst_done", int'(mif.mode_done), 0);
    chk("rst_cur_mode", int'(mif.cur_mode), 0);

    for (int k = 0; k < 6; k++) begin
      do_req(tbl[k].sel, r);
      nm = $sformatf("v%0d", k);
      chk({nm, "_done_cnt"}, r.n_done, 1);
      chk({nm, "_load_cnt"}, r.n_load, tbl[k].change);
      chk({nm, "_blanked"}, r.blank_seen, tbl[k].change);
      chk({nm, "_cur_mode"}, int'(mif.cur_mode), int'(tbl[k].sel));
      chk({nm, "_h_disp"}, int'(mif.h_disp), tbl[k].h);
      chk({nm, "_v_disp"}, int'(mif.v_disp), tbl[k].v);
      chk({nm, "_div"}, int'(mif.clk_div_sel), tbl[k].div);
      chk({nm, "_done_gain"}, r.done_gain, 255);
      chk({nm, "_done_blank"}, int'(mif.pix_blank), 0);
      if (tbl[k].change != 0) begin
        chk({nm, "_rise_edge"}, r.rise_e, 1);
        chk({nm, "_load_edge"}, r.load_e, 3);
        chk({nm, "_fall_edge"}, r.fall_e, EXP_FALL_E);
        chk({nm, "_done_edge"}, r.done_e, 5);
        chk({nm, "_load_h"}, r.ld_h, tbl[k].h);
        chk({nm, "_load_gain"}, r.load_gain, EXP_LOAD_GAIN);
        chk({nm, "_settle_gain"}, r.mid_gain, EXP_MID_GAIN);
        chk({nm, "_min_gain"}, r.min_gain, EXP_MIN_GAIN);
      end else begin
        chk({nm, "_done_lat"}, r.done_cyc, 0);
        chk({nm, "_min_gain"}, r.min_gain, 255);
      end
      @(negedge clk);
      chk({nm, "_done_pulse"}, int'(mif.mode_done), 0);
    end

    // Request held through a change: ready stays low, sel latched only on acceptance.
    for (int k = 0; k < 10000 && !mif.mode_req_ready; k++) @(negedge clk);
    mif.mode_req_sel   = 2'd1;
    mif.mode_req_valid = 1'b1;
    @(negedge clk);
    mif.mode_req_sel = 2'd3;
    viol = 0;
    seen = 0;
    for (int i = 0; i < 8000; i++) begin
      if (mif.mode_done) begin
        seen = 1;
        break;
      end
      if (!mif.busy || mif.mode_req_ready) viol++;
      @(negedge clk);
    end
    chk("held_first_done", seen, 1);
    chk("held_busy_viol", viol, 0);
    chk("held_first_mode", int'(mif.cur_mode), 1);
    @(negedge clk);
    chk("held_idle_ready", int'(mif.mode_req_ready), 1);
    @(negedge clk);
    chk("held_accepted_busy", int'(mif.busy), 1);
    chk("held_accepted_ready", int'(mif.mode_req_ready), 0);
    mif.mode_req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 8000; i++) begin
      if (mif.mode_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("held_second_done", seen, 1);
    chk("held_final_mode", int'(mif.cur_mode), 3);
    chk("held_final_h", int'(mif.h_disp), 1024);

    // Stalled vsync: the watchdog alone must carry dut_to through the change.
    mif2.mode_req_sel   = 2'd2;
    mif2.mode_req_valid = 1'b1;
    ld_i = -1;
    done_i = -1;
    ld_h = -1;
    blank_at_ld = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) mif2.mode_req_valid = 1'b0;
      if (mif2.timing_load) begin
        ld_i        = i;
        ld_h        = int'(mif2.h_disp);
        blank_at_ld = int'(mif2.pix_blank);
      end
      if (mif2.mode_done) begin
        done_i = i;
        break;
      end
    end
    chk("to_load_cycle", ld_i, 303);
    chk("to_load_h", ld_h, 480);
    chk("to_blank_at_load", blank_at_ld, 1);
    chk("to_done_cycle", done_i, 506);
    chk("to_cur_mode", int'(mif2.cur_mode), 2);
    chk("to_done_blank", int'(mif2.pix_blank), 0);

    // Asynchronous reset while blanking.
    @(negedge clk);
    for (int k = 0; k < 10000 && !mif.mode_req_ready; k++) @(negedge clk);
    mif.mode_req_sel   = 2'd1;
    mif.mode_req_valid = 1'b1;
    @(negedge clk);
    mif.mode_req_valid = 1'b0;
    for (int k = 0; k < 3000 && !mif.pix_blank; k++) @(negedge clk);
    chk("rstmid_blank_before", int'(mif.pix_blank), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_blank", int'(mif.pix_blank), 0);
    chk("rstmid_h_disp", int'(mif.h_disp), 640);
    chk("rstmid_v_disp", int'(mif.v_disp), 480);
    chk("rstmid_div", int'(mif.clk_div_sel), 0);
    chk("rstmid_cur_mode", int'(mif.cur_mode), 0);
    chk("rstmid_ready", int'(mif.mode_req_ready), 1);
    chk("rstmid_busy", int'(mif.busy), 0);
    chk("rstmid_gain", int'(mif.pix_gain), 255);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(mif.mode_req_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
